// File: rtl/mem_stage_pkg.sv
// Shared word/strobe types plus the EX->MEM and MEM->WB pipeline payloads
// and FSM state encoding used by the MEM stage.
package mem_stage_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = WORD_W / 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {MSIZE_B, MSIZE_H, MSIZE_W} mem_size_t;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE, ST_DRAIN} mem_stage_state_t;

  typedef struct packed {
    word_t     alu_result;
    word_t     rt_word;
    logic [4:0] wr_reg;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    mem_size_t mem_size;
    logic      mem_unsigned;
  } e_m_reg_t;

  typedef struct packed {
    word_t      alu_result;
    word_t      mem_rdata;
    logic [4:0] wr_reg;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_err;
    logic       mem_misalign;
  } m_w_reg_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lo);
    case (size)
      MSIZE_B: return 1'b0;
      MSIZE_H: return lo[0];
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store strobes and lane-replicated write data,
// plus load lane selection with sign/zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]        addr_lo_i,
  input  mem_size_t         size_i,
  input  logic              unsigned_i,
  input  word_t             rt_word_i,
  input  word_t             rdata_i,
  output logic [STRB_W-1:0] wstrb_o,
  output word_t             wdata_o,
  output word_t             ld_data_o
);

  logic [1:0]        off;
  logic [STRB_W-1:0] mask;
  logic [15:0]       lane;

  // Low address bits that cannot be honoured for the access size are dropped.
  always_comb begin
    off     = 2'b00;
    mask    = 4'b1111;
    wdata_o = rt_word_i;
    case (size_i)
      MSIZE_B: begin
        off     = addr_lo_i;
        mask    = 4'b0001;
        wdata_o = {4{rt_word_i[7:0]}};
      end
      MSIZE_H: begin
        off     = {addr_lo_i[1], 1'b0};
        mask    = 4'b0011;
        wdata_o = {2{rt_word_i[15:0]}};
      end
      default: ;
    endcase
    wstrb_o = mask << off;
    lane    = 16'(rdata_i >> {off, 3'b000});
    case (size_i)
      MSIZE_B: ld_data_o = {{24{lane[7] & ~unsigned_i}}, lane[7:0]};
      MSIZE_H: ld_data_o = {{16{lane[15] & ~unsigned_i}}, lane[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: holds the EX->MEM entry, runs the data-bus handshake and
// hands results to WB with backpressure. MEM_ALIGN_CHECK_EN enables misalignment traps.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  e_m_reg_t          e_m_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output m_w_reg_t          m_w_reg,
  output logic              dreq_valid,
  input  logic              dreq_ready,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [STRB_W-1:0] dreq_wstrb,
  output word_t             dreq_wdata,
  input  logic              dresp_valid,
  input  word_t             dresp_data
);

  localparam int TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mem_stage: DATA_W must be 32");
  end
  if (ADDR_W < 3 || ADDR_W > WORD_W) begin : g_bad_addr_w
    $error("mem_stage: ADDR_W must be in 3..32");
  end

  mem_stage_state_t  state_q;
  e_m_reg_t          pl_q;
  m_w_reg_t          out_q;
  logic              out_valid_q;
  logic              dreq_valid_q;
  logic              err_pend_q;
  logic [TMO_W-1:0]  tmo_q;

  logic              accept_d;
  logic              mis_in_d;
  logic              launch_req_d;
  logic              timeout_d;
  logic [STRB_W-1:0] strb_d;
  word_t             ld_data_d;
  m_w_reg_t          out_direct_d;
  m_w_reg_t          out_resp_d;
  m_w_reg_t          out_tmo_d;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_in_d = is_misaligned(e_m_reg.mem_size, e_m_reg.alu_result[1:0]);
`else
  assign mis_in_d = 1'b0;
`endif

  // A flush in the same cycle blocks acceptance so EX never hands off a squashed op.
  assign in_ready     = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign accept_d     = in_valid & in_ready;
  assign launch_req_d = (e_m_reg.mem_read | e_m_reg.mem_write) & ~mis_in_d;
  assign timeout_d    = (TIMEOUT_CYC != 0) && (tmo_q == TMO_W'(TIMEOUT_CYC));

  mem_align u_align (
    .addr_lo_i (pl_q.alu_result[1:0]),
    .size_i    (pl_q.mem_size),
    .unsigned_i(pl_q.mem_unsigned),
    .rt_word_i (pl_q.rt_word),
    .rdata_i   (dresp_data),
    .wstrb_o   (strb_d),
    .wdata_o   (dreq_wdata),
    .ld_data_o (ld_data_d)
  );

  assign dreq_addr  = {pl_q.alu_result[ADDR_W-1:2], 2'b00};
  assign dreq_wstrb = pl_q.mem_write ? strb_d : '0;
  assign dreq_valid = dreq_valid_q;
  assign out_valid  = out_valid_q;
  assign m_w_reg    = out_q;

  always_comb begin
    out_direct_d              = '0;
    out_direct_d.alu_result   = e_m_reg.alu_result;
    out_direct_d.wr_reg       = e_m_reg.wr_reg;
    out_direct_d.reg_write    = e_m_reg.reg_write;
    out_direct_d.mem_to_reg   = e_m_reg.mem_read;
    out_direct_d.mem_misalign = mis_in_d;

    out_resp_d            = '0;
    out_resp_d.alu_result = pl_q.alu_result;
    out_resp_d.wr_reg     = pl_q.wr_reg;
    out_resp_d.reg_write  = pl_q.reg_write;
    out_resp_d.mem_to_reg = pl_q.mem_read;
    out_resp_d.mem_rdata  = pl_q.mem_read ? ld_data_d : '0;

    out_tmo_d           = out_resp_d;
    out_tmo_d.mem_rdata = '0;
    out_tmo_d.mem_err   = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      pl_q         <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      dreq_valid_q <= 1'b0;
      err_pend_q   <= 1'b0;
      tmo_q        <= '0;
    end else if (accept_d) begin
      pl_q         <= e_m_reg;
      tmo_q        <= '0;
      err_pend_q   <= 1'b0;
      dreq_valid_q <= launch_req_d;
      out_valid_q  <= ~launch_req_d;
      state_q      <= launch_req_d ? ST_REQ : ST_DONE;
      if (!launch_req_d) out_q <= out_direct_d;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_REQ: begin
          if (flush) begin
            dreq_valid_q <= 1'b0;
            err_pend_q   <= 1'b0;
            state_q      <= dreq_ready ? ST_DRAIN : ST_IDLE;
          end else if (dreq_ready) begin
            dreq_valid_q <= 1'b0;
            tmo_q        <= '0;
            state_q      <= ST_WAIT;
          end
        end
        // A response arriving with the flush is already absorbed, so no DRAIN is needed.
        ST_WAIT: begin
          if (flush) begin
            err_pend_q <= 1'b0;
            state_q    <= dresp_valid ? ST_IDLE : ST_DRAIN;
          end else if (dresp_valid) begin
            out_q       <= out_resp_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (timeout_d) begin
            out_q      <= out_tmo_d;
            err_pend_q <= 1'b1;
            state_q    <= ST_DRAIN;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (flush || out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (dresp_valid) begin
            out_valid_q <= err_pend_q & ~flush;
            state_q     <= (err_pend_q && !flush) ? ST_DONE : ST_IDLE;
            err_pend_q  <= 1'b0;
          end else if (flush) begin
            err_pend_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
